// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO and its stream reader.
package fifo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned FIFO_DEPTH         = 8;
    localparam int unsigned OCC_W              = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } rd_state_e;

endpackage : fifo_pkg

// File: rtl/stream_skid_buf.sv
// Two-entry register FIFO that holds words returned by the FIFO read port
// until the downstream consumer accepts them. Entry 0 is always the head.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [DATA_WIDTH-1:0] head_data
);

    logic [DATA_WIDTH-1:0] e0_q, e0_d;
    logic [DATA_WIDTH-1:0] e1_q, e1_d;
    logic [OCC_W-1:0]      occ_q, occ_d;

    // Next entry contents and occupancy; pop is only ever asserted with occ != 0.
    always_comb begin
        e0_d  = e0_q;
        e1_d  = e1_q;
        occ_d = occ_q;
        case ({push, pop})
            2'b10: begin
                case (occ_q)
                    2'd0:    e0_d = push_data;
                    2'd1:    e1_d = push_data;
                    default: ;
                endcase
                occ_d = occ_q + OCC_W'(1);
            end
            2'b01: begin
                e0_d  = e1_q;
                occ_d = occ_q - OCC_W'(1);
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    e0_d = push_data;
                end else begin
                    e0_d = e1_q;
                    e1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    // Entry and occupancy registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e0_q  <= '0;
            e1_q  <= '0;
            occ_q <= '0;
        end else begin
            e0_q  <= e0_d;
            e1_q  <= e1_d;
            occ_q <= occ_d;
        end
    end

    assign occ       = occ_q;
    assign head_data = e0_q;

endmodule : stream_skid_buf

// File: rtl/fifo_stream_reader.sv
// Read-side controller for the synchronous fifo: issues reads, absorbs the
// one-cycle read latency and presents words on a valid/ready stream.
// Optional feature macro: FIFO_STREAM_READER_STATS_EN adds a transfer counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data_out,
    output logic                  fifo_cs,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  busy
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [31:0]           word_count
`endif
);

    rd_state_e         state_q, state_d;
    logic              inflight_q, inflight_d;
    logic [OCC_W-1:0]  occ;
    logic              pop_c;
    logic              rd_en_c;
    logic [2:0]        level_c;

    // Buffer holding returned words until accepted downstream.
    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_data_out),
        .pop       (pop_c),
        .occ       (occ),
        .head_data (m_data)
    );

    assign m_valid = (occ != '0);

    // Read issue: only while the buffer plus the word in flight leaves a free slot.
    always_comb begin
        pop_c      = m_valid && m_ready;
        level_c    = 3'(occ) + 3'(inflight_q) - 3'(pop_c);
        rd_en_c    = (state_q == ST_RUN) && !fifo_empty && (level_c < 3'd2);
        inflight_d = rd_en_c;
    end

    assign fifo_rd_en = rd_en_c;
    assign fifo_cs    = rd_en_c;
    assign busy       = (state_q != ST_IDLE);

    // Next-state logic; en wins over completion while draining.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (!inflight_q && (occ == '0)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and in-flight registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
        end
    end

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [31:0] word_count_q, word_count_d;

    // Count of completed output transfers, wrapping naturally.
    always_comb begin
        word_count_d = word_count_q;
        if (pop_c) word_count_d = word_count_q + 32'd1;
    end

    // Transfer counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) word_count_q <= '0;
        else        word_count_q <= word_count_d;
    end

    assign word_count = word_count_q;
`endif

endmodule : fifo_stream_reader

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side controller for the synchronous `fifo`. It issues `cs`/`rd_en` to the FIFO, absorbs the FIFO's one-cycle read latency, and presents words on a valid/ready stream with a 2-entry output buffer. With `m_ready` held high it sustains one word per cycle. It sits between the FIFO read port and any downstream consumer.

## Interface
- `DATA_WIDTH`, default 32: word width; must match the FIFO.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: when high, the block pulls words while the FIFO is non-empty.
- `fifo_empty` in 1: FIFO `empty` flag, registered in the FIFO.
- `fifo_data_out` in DATA_WIDTH: FIFO `data_out`; valid the cycle after a read is sampled.
- `fifo_cs` out 1: FIFO chip select; equals `fifo_rd_en`.
- `fifo_rd_en` out 1: FIFO read strobe, one word per cycle high.
- `m_valid` out 1: output word available.
- `m_ready` in 1: consumer accepts; a transfer occurs when `m_valid && m_ready`.
- `m_data` out DATA_WIDTH: output word, stable while `m_valid && !m_ready`.
- `busy` out 1: high in RUN or DRAIN.
- `word_count` out 32: present only with `FIFO_STREAM_READER_STATS_EN`.

## Operation
- **Reset values:** state IDLE; `fifo_cs`, `fifo_rd_en`, `m_valid` and `busy` are 0; `m_data` is 0; buffer occupancy `occ` is 0; in-flight flag `inflight` is 0; `word_count` is 0.
- **Issue rule (combinational from registered state and `fifo_empty`):**
  - `fifo_rd_en = (state==RUN) && !fifo_empty && (occ + inflight - pop) < 2`.
  - `pop = m_valid && m_ready`.
- **In-flight tracking:** `inflight <= fifo_rd_en`. When `inflight` is 1, `fifo_data_out` is written into the buffer at the same edge.
- **Output buffer:** 2-entry register FIFO with `occ` in 0..2.
  - `m_data` is the head entry; `m_valid = (occ != 0)`.
  - A simultaneous push and pop keeps `occ` unchanged, and order is preserved.
  - The buffer never overflows; the issue rule guarantees this.
- **States:**
  - IDLE: goes to RUN when `en`=1.
  - RUN: goes to DRAIN when `en`=0.
  - DRAIN: no new reads; goes to IDLE when `inflight`=0 and `occ`=0, or back to RUN if `en`=1.
- **FIFO empty:** no read is issued. A word becomes readable on the cycle after `fifo_empty` falls.
- **Consumer stall (`m_ready`=0):** reads stop once `occ + inflight` = 2. No word is lost or duplicated.
- **`en` dropping mid-stream:** a read already issued still lands in the buffer and is delivered in DRAIN.
- **Reset mid-operation:** buffered and in-flight words are discarded. The FIFO's own reset is expected to occur together with this block's reset.

## Timing
- `fifo_rd_en` high in cycle t → data captured at the end of t+1 → `m_valid` high in t+2. Latency from read strobe to output is 2 cycles.
- First word latency: `en` rising in IDLE → RUN next cycle → first `fifo_rd_en` in that cycle (if non-empty) → `m_valid` 2 cycles later.
- Steady state with `m_ready`=1 and FIFO non-empty: `fifo_rd_en` high every cycle and one transfer per cycle.
- `m_ready` rising after a stall: reads resume in the same cycle as the pop.

## Configuration
- `FIFO_STREAM_READER_STATS_EN`:
  - Defined: adds the `word_count` port, a 32-bit count of completed `m_valid && m_ready` transfers. It wraps at 2^32 and resets to 0.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_pkg` holds:
  - The state enum (IDLE, RUN, DRAIN).
  - The default `DATA_WIDTH` constant.
  - The `FIFO_DEPTH` constant used by the FIFO and the benches.
- One sub-module, `stream_skid_buf`: the 2-entry buffer with push/pop/occ. The reader's FSM and issue logic stay in the top module.

## Test plan
- **Three-word read:** write 1, 10, 100; `en`=1, `m_ready`=1 → `m_data` 1, 10, 100 on three consecutive cycles; first `m_valid` 2 cycles after the first `fifo_rd_en`; `fifo_empty` high afterward with no extra read.
- **Interleaved writes:** interleave a single write of 2**i with reading, for i=0..7 → each word is delivered exactly once, in order; `fifo_rd_en` never asserts while `fifo_empty`=1.
- **Full FIFO, stalled consumer:** fill with 1, 2, 4 … 128 (8 words); hold `m_ready`=0 → exactly 2 reads are issued and then `fifo_rd_en` stays 0. Release `m_ready` → the remaining 8 words arrive back-to-back, with no gaps after the first.
- **Drain:** drop `en` on the cycle a read issues → that word is still delivered; state passes through DRAIN to IDLE; `busy` falls the cycle after the buffer empties.
- **Reset mid-stream:** assert `rst_n`=0 with `occ`=2 → `m_valid`, `fifo_rd_en` and `busy` go to 0 immediately (asynchronously).
- **Stats build:** with `FIFO_STREAM_READER_STATS_EN` defined and 11 words transferred → `word_count`=11. Under a consumer stall → the count holds.
